// File: rtl/ssd_scan_scheduler.sv
// Scans an 8-digit common-anode 7-seg display with ON/BLANK slots, digit skip and leading-zero blanking.
// Registered outputs; one-deep pending buffer, upd_ready low until the held word is taken at a frame boundary.
module ssd_scan_scheduler #(
  parameter int NUM_DIGITS   = 8,
  parameter int ON_CYCLES    = 250000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W        = 18
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    upd_valid,
  input  logic [4*NUM_DIGITS-1:0] upd_data,
  output logic                    upd_ready,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lz_suppress,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic [7:0]              cathode_n,
  output logic                    frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ON    = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        timer_q, timer_d;
  logic                    go_idle_q, go_idle_d;
  logic [4*NUM_DIGITS-1:0] active_q, pending_q, eff_data;
  logic                    pend_q;
  logic                    boundary, load_cat, clr_cat;
  logic [NUM_DIGITS-1:0]   anode_d;
  logic [7:0]              cathode_d;
  logic                    any_en, above_found, lz_blank;
  logic [IDX_W-1:0]        lowest_idx, above_idx;
  logic [3:0]              nib;
  logic [6:0]              seg;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0:    seg7 = 7'b0000001;
      4'h1:    seg7 = 7'b1001111;
      4'h2:    seg7 = 7'b0010010;
      4'h3:    seg7 = 7'b0000110;
      4'h4:    seg7 = 7'b1001100;
      4'h5:    seg7 = 7'b0100100;
      4'h6:    seg7 = 7'b0100000;
      4'h7:    seg7 = 7'b0001111;
      4'h8:    seg7 = 7'b0000000;
      4'h9:    seg7 = 7'b0000100;
      4'hA:    seg7 = 7'b0001000;
      4'hB:    seg7 = 7'b1100000;
      4'hC:    seg7 = 7'b0110001;
      4'hD:    seg7 = 7'b1000010;
      4'hE:    seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction

  // Descending scan leaves the lowest match in each result.
  always_comb begin
    any_en      = |dig_en;
    lowest_idx  = '0;
    above_found = 1'b0;
    above_idx   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (dig_en[i]) lowest_idx = IDX_W'(i);
      if (dig_en[i] && (IDX_W'(i) > idx_q)) begin
        above_found = 1'b1;
        above_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    go_idle_d = go_idle_q;
    boundary  = 1'b0;
    load_cat  = 1'b0;
    clr_cat   = 1'b0;
    case (state_q)
      S_IDLE: begin
        boundary = 1'b1;
        timer_d  = '0;
        if (any_en) begin
          state_d  = S_ON;
          idx_d    = lowest_idx;
          load_cat = 1'b1;
        end
      end
      S_ON: begin
        if (timer_q == ON_LAST) begin
          // Next digit is picked here so its cathodes settle during the blank gap.
          timer_d   = '0;
          go_idle_d = !any_en;
          clr_cat   = !any_en;
          state_d   = HAS_BLANK ? S_BLANK : (any_en ? S_ON : S_IDLE);
          if (any_en) begin
            idx_d    = above_found ? above_idx : lowest_idx;
            boundary = !above_found;
            load_cat = 1'b1;
          end
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      S_BLANK: begin
        if (timer_q == BLANK_LAST) begin
          timer_d = '0;
          state_d = go_idle_q ? S_IDLE : S_ON;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    eff_data = (boundary && pend_q) ? pending_q : active_q;
    nib      = eff_data[{idx_d, 2'b00} +: 4];
    lz_blank = lz_suppress && (idx_d != '0) && ((eff_data >> {idx_d, 2'b00}) == '0);
    seg      = lz_blank ? 7'h7F : seg7(nib);
    anode_d  = '1;
    if (state_d == S_ON) anode_d[idx_d] = 1'b0;
    cathode_d = cathode_n;
    if (load_cat) cathode_d = {seg, ~dp_mask[idx_d]};
    else if (clr_cat) cathode_d = 8'hFF;
  end

  assign upd_ready = ~pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      timer_q    <= '0;
      go_idle_q  <= 1'b0;
      active_q   <= '0;
      pending_q  <= '0;
      pend_q     <= 1'b0;
      anode_n    <= '1;
      cathode_n  <= 8'hFF;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      go_idle_q  <= go_idle_d;
      anode_n    <= anode_d;
      cathode_n  <= cathode_d;
      frame_tick <= boundary;
      if (pend_q) begin
        if (boundary) begin
          active_q <= pending_q;
          pend_q   <= 1'b0;
        end
      end else if (upd_valid) begin
        pending_q <= upd_data;
        pend_q    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_scheduler.sv
// Bench for ssd_scan_scheduler: two instances (with and without blank gap) against a slot-schedule model.
module tb_ssd_scan_scheduler;
  localparam int ON0 = 4, BL0 = 2, ON1 = 3, BL1 = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, upd_valid, lz_suppress;
  logic [31:0] upd_data;
  logic [7:0]  dig_en, dp_mask;
  logic        rdy0, rdy1, tk0, tk1;
  logic [7:0]  an0, an1, ca0, ca1;

  ssd_scan_scheduler #(.NUM_DIGITS(8), .ON_CYCLES(ON0), .BLANK_CYCLES(BL0), .CNT_W(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_data(upd_data), .upd_ready(rdy0),
    .dig_en(dig_en), .dp_mask(dp_mask), .lz_suppress(lz_suppress),
    .anode_n(an0), .cathode_n(ca0), .frame_tick(tk0));

  ssd_scan_scheduler #(.NUM_DIGITS(8), .ON_CYCLES(ON1), .BLANK_CYCLES(BL1), .CNT_W(2)) u_dut_nb (
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_data(upd_data), .upd_ready(rdy1),
    .dig_en(dig_en), .dp_mask(dp_mask), .lz_suppress(lz_suppress),
    .anode_n(an1), .cathode_n(ca1), .frame_tick(tk1));

  typedef struct packed { logic [7:0] an; logic [7:0] ca; } slot_t;
  slot_t       sq0[$];
  slot_t       sq1[$];
  bit          m_idle [2];
  int          m_cur  [2];
  logic [31:0] m_act  [2];
  logic [31:0] m_pend [2];
  bit          m_pf   [2];
  logic [7:0]  e_an   [2];
  logic [7:0]  e_ca   [2];
  bit          e_tk   [2];
  bit          e_rdy  [2];
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic [7:0] exp_cat(input logic [31:0] data, input int d,
                                         input logic [7:0] dpm, input bit lz);
    logic [6:0] s;
    s = seg_of(data[4*d +: 4]);
    if (lz && d != 0 && (data >> (4*d)) == 32'd0) s = 7'h7F;
    return {s, ~dpm[d]};
  endfunction

  function automatic logic [7:0] an_of(input int d);
    logic [7:0] v;
    v = 8'hFF;
    v[d] = 1'b0;
    return v;
  endfunction

  task automatic push_slots(input int k, input logic [7:0] an, input logic [7:0] ca, input int n);
    for (int i = 0; i < n; i++) begin
      if (k == 0) sq0.push_back({an, ca});
      else        sq1.push_back({an, ca});
    end
  endtask

  task automatic model_reset();
    sq0.delete();
    sq1.delete();
    for (int k = 0; k < 2; k++) begin
      m_idle[k] = 1'b1;  m_cur[k] = 0;
      m_act[k]  = '0;    m_pend[k] = '0;  m_pf[k] = 1'b0;
      e_an[k] = 8'hFF;   e_ca[k] = 8'hFF; e_tk[k] = 1'b0; e_rdy[k] = 1'b1;
    end
  endtask

  // When a slot schedule runs out, decide the next digit and queue its whole BLANK+ON slot.
  task automatic model_step(input int k);
    int          on_n, bl_n, nxt;
    bit          bnd, empty;
    logic [31:0] eff;
    logic [7:0]  ca;
    slot_t       s;
    on_n  = (k == 0) ? ON0 : ON1;
    bl_n  = (k == 0) ? BL0 : BL1;
    bnd   = 1'b0;
    empty = (k == 0) ? (sq0.size() == 0) : (sq1.size() == 0);
    if (empty) begin
      if (m_idle[k]) begin
        bnd = 1'b1;
        eff = m_pf[k] ? m_pend[k] : m_act[k];
        if (dig_en == 8'h00) begin
          push_slots(k, 8'hFF, 8'hFF, 1);
        end else begin
          nxt = -1;
          for (int i = 0; i < 8; i++) if (nxt < 0 && dig_en[i]) nxt = i;
          push_slots(k, an_of(nxt), exp_cat(eff, nxt, dp_mask, lz_suppress), on_n);
          m_cur[k]  = nxt;
          m_idle[k] = 1'b0;
        end
      end else begin
        nxt = -1;
        for (int i = m_cur[k] + 1; i < 8; i++) if (nxt < 0 && dig_en[i]) nxt = i;
        if (nxt < 0) begin
          for (int i = 0; i <= m_cur[k]; i++) if (nxt < 0 && dig_en[i]) nxt = i;
          bnd = (nxt >= 0);
        end
        if (nxt < 0) begin
          push_slots(k, 8'hFF, 8'hFF, bl_n + 1);
          m_idle[k] = 1'b1;
        end else begin
          eff = (bnd && m_pf[k]) ? m_pend[k] : m_act[k];
          ca  = exp_cat(eff, nxt, dp_mask, lz_suppress);
          push_slots(k, 8'hFF, ca, bl_n);
          push_slots(k, an_of(nxt), ca, on_n);
          m_cur[k] = nxt;
        end
      end
    end
    if (k == 0) s = sq0.pop_front();
    else        s = sq1.pop_front();
    e_an[k] = s.an;
    e_ca[k] = s.ca;
    e_tk[k] = bnd;
    if (m_pf[k]) begin
      if (bnd) begin
        m_act[k] = m_pend[k];
        m_pf[k]  = 1'b0;
      end
    end else if (upd_valid) begin
      m_pend[k] = upd_data;
      m_pf[k]   = 1'b1;
    end
    e_rdy[k] = !m_pf[k];
  endtask

  task automatic chk_reset(input string tag);
    chk_eq({tag, "_an0"}, an0, 8'hFF);  chk_eq({tag, "_ca0"}, ca0, 8'hFF);
    chk_eq({tag, "_rdy0"}, rdy0, 1);    chk_eq({tag, "_tk0"}, tk0, 0);
    chk_eq({tag, "_an1"}, an1, 8'hFF);  chk_eq({tag, "_ca1"}, ca1, 8'hFF);
    chk_eq({tag, "_rdy1"}, rdy1, 1);    chk_eq({tag, "_tk1"}, tk1, 0);
  endtask

  // Inputs are already driven (at a negedge); predict, let the edge pass, then compare.
  task automatic step_cycle();
    model_step(0);
    model_step(1);
    @(negedge clk);
    chk_eq("anode0", an0, e_an[0]);   chk_eq("cathode0", ca0, e_ca[0]);
    chk_eq("tick0", tk0, e_tk[0]);    chk_eq("ready0", rdy0, e_rdy[0]);
    chk_eq("anode1", an1, e_an[1]);   chk_eq("cathode1", ca1, e_ca[1]);
    chk_eq("tick1", tk1, e_tk[1]);    chk_eq("ready1", rdy1, e_rdy[1]);
  endtask

  task automatic async_reset_mid_on();
    upd_valid = 1'b0;
    dig_en    = dig_en | 8'h01;
    for (int i = 0; i < 40 && e_an[0] == 8'hFF; i++) step_cycle();
    #1 rst_n = 1'b0;
    #1 chk_reset("rst_async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int last_tk, n_tk;
    rst_n = 1'b0; upd_valid = 1'b0; upd_data = '0;
    dig_en = 8'h00; dp_mask = 8'h00; lz_suppress = 1'b0;
    model_reset();
    #12;
    chk_reset("rst_init");
    @(negedge clk);
    rst_n = 1'b1;

    // four enabled digits, 0x1234, frame period and digit-0 pattern
    dig_en = 8'h0F; upd_valid = 1'b1; upd_data = 32'h0000_1234;
    step_cycle();
    upd_valid = 1'b0;
    last_tk = 0; n_tk = 0;
    for (int i = 1; i < 80; i++) begin
      step_cycle();
      if (tk0) begin
        n_tk++;
        if (n_tk >= 2) chk_eq("t2_period", i - last_tk, 24);
        last_tk = i;
      end
      if (i > 30 && an0 == 8'hFE) chk_eq("t2_digit0", ca0, 8'h99);
    end

    // back-to-back words: second waits for a frame boundary
    upd_valid = 1'b1; upd_data = 32'h1111_1111;
    step_cycle();
    upd_data = 32'h2222_2222;
    for (int i = 0; i < 40; i++) step_cycle();
    upd_valid = 1'b0;
    for (int i = 0; i < 40; i++) step_cycle();

    // leading-zero suppression on 0x00000050
    lz_suppress = 1'b1; dig_en = 8'hFF; upd_valid = 1'b1; upd_data = 32'h0000_0050;
    for (int i = 0; i < 30; i++) step_cycle();
    upd_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step_cycle();
      if (i >= 50) begin
        if (an0 == 8'hFE)      chk_eq("t4_digit0", ca0, 8'h03);
        else if (an0 == 8'hFD) chk_eq("t4_digit1", ca0, 8'h49);
        else if (an0 != 8'hFF) chk_eq("t4_upper", ca0, 8'hFF);
      end
    end

    // sparse enables, then all off with a word pending, then two digits
    lz_suppress = 1'b0; dig_en = 8'h81;
    for (int i = 0; i < 50; i++) step_cycle();
    dig_en = 8'h00; upd_valid = 1'b1; upd_data = $urandom;
    step_cycle();
    upd_valid = 1'b0;
    for (int i = 0; i < 20; i++) step_cycle();
    dig_en = 8'h03;
    for (int i = 0; i < 40; i++) step_cycle();

    // random traffic with an asynchronous reset in the middle
    for (int i = 0; i < 2500; i++) begin
      upd_valid = ($urandom_range(3) == 0);
      upd_data  = $urandom >> $urandom_range(31);
      if ($urandom_range(63) == 0) dig_en = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(31) == 0) dp_mask = 8'($urandom);
      if ($urandom_range(63) == 0) lz_suppress = 1'($urandom_range(1));
      step_cycle();
      if (i == 1200) async_reset_mid_on();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
